// File: rtl/c3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : c3_pkg
// Brief    : Shared C3 source-buffer constants, address field map and states
// Revision : 1.0
// ============================================================================
package c3_pkg;

  localparam int C3_NUM_BUF     = 6;
  localparam int C3_BUF_DEPTH   = 256;

  // Bank write address layout: {buffer index, offset}
  localparam int C3_BUF_IDX_MSB = 15;
  localparam int C3_BUF_IDX_LSB = 8;
  localparam int C3_OFS_MSB     = 7;
  localparam int C3_OFS_LSB     = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } c3_state_e;

endpackage
`default_nettype wire

// File: rtl/c3_src_buf_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : c3_src_buf_loader_if
// Brief    : Input word stream and bank write port of the source buffer loader
// Revision : 1.0
// ============================================================================
interface c3_src_buf_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 32
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              we;

  modport master (
    output s_valid, s_data,
    input  s_ready, wr_data, wr_addr, we
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, wr_data, wr_addr, we
  );
endinterface
`default_nettype wire

// File: rtl/c3_wr_addr_cnt.sv
`default_nettype none
// ============================================================================
// Module   : c3_wr_addr_cnt
// Brief    : Nested offset / buffer-index counter for buffer-major writes
// Revision : 1.0
// ============================================================================
module c3_wr_addr_cnt (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       clr,
  input  wire logic       inc,
  input  wire logic [8:0] len,
  input  wire logic [7:0] nbuf,
  output logic      [7:0] idx,
  output logic      [7:0] ofs,
  output logic            last
);

  logic [7:0] r_idx;
  logic [7:0] r_ofs;
  logic       w_ofs_last;

  // 9-bit compare so a 256-word buffer ends at offset 255 without wrapping
  assign w_ofs_last = ({1'b0, r_ofs} == (len - 9'd1));
  assign last       = w_ofs_last && (r_idx == (nbuf - 8'd1));
  assign idx        = r_idx;
  assign ofs        = r_ofs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= 8'd0;
      r_ofs <= 8'd0;
    end else if (clr) begin
      r_idx <= 8'd0;
      r_ofs <= 8'd0;
    end else if (inc) begin
      if (w_ofs_last) begin
        r_ofs <= 8'd0;
        r_idx <= r_idx + 8'd1;
      end else begin
        r_ofs <= r_ofs + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/c3_src_buf_loader.sv
`default_nettype none
// ============================================================================
// Module   : c3_src_buf_loader
// Brief    : Writes a valid/ready word stream buffer-major into the C3 source
//            buffer bank and flags src_rdy once a complete load has landed
// Revision : 1.0
// ============================================================================
module c3_src_buf_loader
  import c3_pkg::*;
#(
  parameter int NUM_BUF = C3_NUM_BUF,
  parameter int DEPTH   = C3_BUF_DEPTH,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 32
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       start,
  input  wire logic [7:0] cfg_nbuf,
  input  wire logic [7:0] cfg_len,
  c3_src_buf_loader_if.slave bus,
  output logic            busy,
  output logic            done,
  output logic            cfg_err,
  output logic            src_rdy
);

  localparam logic [7:0] c_num_buf = 8'(NUM_BUF);
  localparam logic [8:0] c_depth   = 9'(DEPTH);

  c3_state_e         r_state;
  logic [7:0]        r_nbuf;
  logic [8:0]        r_len;
  logic              r_we;
  logic              r_done;
  logic              r_cfg_err;
  logic              r_src_rdy;
  logic [DATA_W-1:0] r_wr_data;
  logic [ADDR_W-1:0] r_wr_addr;

  logic [7:0]        w_idx;
  logic [7:0]        w_ofs;
  logic              w_last;
  logic              w_beat;
  logic              w_cfg_ok;
  logic              w_clr;
  logic [15:0]       w_addr16;

  assign w_cfg_ok    = (cfg_nbuf != 8'd0) && (cfg_nbuf <= c_num_buf);
  assign w_clr       = (r_state == IDLE) && start && w_cfg_ok;
  assign w_beat      = bus.s_valid && (r_state == LOAD);

  assign bus.s_ready = (r_state == LOAD);
  assign bus.we      = r_we;
  assign bus.wr_data = r_wr_data;
  assign bus.wr_addr = r_wr_addr;
  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign cfg_err     = r_cfg_err;
  assign src_rdy     = r_src_rdy;

  always_comb begin
    w_addr16 = 16'd0;
    w_addr16[C3_BUF_IDX_MSB:C3_BUF_IDX_LSB] = w_idx;
    w_addr16[C3_OFS_MSB:C3_OFS_LSB]         = w_ofs;
  end

  c3_wr_addr_cnt u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .inc   (w_beat),
    .len   (r_len),
    .nbuf  (r_nbuf),
    .idx   (w_idx),
    .ofs   (w_ofs),
    .last  (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_nbuf    <= 8'd0;
      r_len     <= 9'd0;
      r_we      <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_src_rdy <= 1'b0;
      r_wr_data <= '0;
      r_wr_addr <= '0;
    end else begin
      r_we      <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_cfg_ok) begin
              r_nbuf    <= cfg_nbuf;
              r_len     <= (cfg_len == 8'd0) ? c_depth : {1'b0, cfg_len};
              r_src_rdy <= 1'b0;
              r_state   <= LOAD;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          // wr_data/wr_addr only move on a beat so they hold across stalls
          if (w_beat) begin
            r_we      <= 1'b1;
            r_wr_data <= bus.s_data;
            r_wr_addr <= {{(ADDR_W-16){1'b0}}, w_addr16};
            if (w_last) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_done    <= 1'b1;
          r_src_rdy <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_c3_src_buf_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_c3_src_buf_loader
// Brief    : Self-checking bench for c3_src_buf_loader (vector table + scoreboard)
// Revision : 1.0
// ============================================================================
module tb_c3_src_buf_loader;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] nbuf;
    logic [7:0] len;
    bit         legal;
    int         gap;
  } vec_t;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       start    = 1'b0;
  logic [7:0] cfg_nbuf = 8'd0;
  logic [7:0] cfg_len  = 8'd0;
  logic       busy;
  logic       done;
  logic       cfg_err;
  logic       src_rdy;

  int  checks  = 0;
  int  errors  = 0;
  int  we_cnt  = 0;
  bit  prev_we = 1'b0;
  bit  exp_rdy = 1'b0;
  wr_t q[$];
  wr_t mon_e;
  vec_t tv[7];

  c3_src_buf_loader_if #(.DATA_W(16), .ADDR_W(32)) ifc ();

  c3_src_buf_loader #(
    .NUM_BUF (6),
    .DEPTH   (256),
    .DATA_W  (16),
    .ADDR_W  (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cfg_nbuf (cfg_nbuf),
    .cfg_len  (cfg_len),
    .bus      (ifc),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err),
    .src_rdy  (src_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Write-port monitor: every we must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.we) begin
        we_cnt++;
        if (q.size() == 0) begin
          chk("unexpected_we", 32'(ifc.wr_addr), 32'hFFFF_FFFF);
        end else begin
          mon_e = q.pop_front();
          chk("wr_addr", ifc.wr_addr, mon_e.addr);
          chk("wr_data", 32'(ifc.wr_data), 32'(mon_e.data));
        end
      end
      if (done) chk("done_after_last_we", 32'(prev_we && !ifc.we), 32'd1);
      prev_we = ifc.we;
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic do_start(input logic [7:0] nb, input logic [7:0] ln, input bit legal);
    int base;
    @(negedge clk);
    start = 1'b1; cfg_nbuf = nb; cfg_len = ln;
    @(negedge clk);
    start = 1'b0; cfg_nbuf = 8'hAA; cfg_len = 8'h55;
    base = we_cnt;
    if (legal) exp_rdy = 1'b0;
    chk("cfg_err_after_start", 32'(cfg_err), 32'(!legal));
    chk("busy_after_start", 32'(busy), 32'(legal));
    chk("s_ready_after_start", 32'(ifc.s_ready), 32'(legal));
    chk("src_rdy_after_start", 32'(src_rdy), 32'(exp_rdy));
    if (!legal) begin
      @(negedge clk);
      chk("cfg_err_single_pulse", 32'(cfg_err), 32'd0);
      chk("busy_stays_idle", 32'(busy), 32'd0);
      @(negedge clk);
      chk("no_we_on_illegal", 32'(we_cnt - base), 32'd0);
      chk("src_rdy_unchanged", 32'(src_rdy), 32'(exp_rdy));
    end
  endtask

  task automatic run_load(input logic [7:0] nb, input logic [7:0] ln, input int gap, input bit mid_start);
    int len9  = (ln == 8'd0) ? 256 : int'(ln);
    int total = int'(nb) * len9;
    int limit = total * 30 + 50;
    int k     = 0;
    int cyc   = 0;
    int base  = we_cnt;
    bit issued = 1'b0;
    while (k < total && cyc < limit) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (mid_start && !issued && k == total / 2) begin
        start = 1'b1; cfg_nbuf = 8'd3; cfg_len = 8'd5; issued = 1'b1;
      end
      ifc.s_valid = (gap == 0) || ($urandom_range(99) >= gap);
      ifc.s_data  = (gap == 0) ? 16'(k) : 16'($urandom);
      #1;
      if (ifc.s_valid && ifc.s_ready) begin
        q.push_back('{addr: 32'(((k / len9) << 8) | (k % len9)), data: ifc.s_data});
        k++;
      end
    end
    chk("beats_accepted", 32'(k), 32'(total));
    @(negedge clk);
    start = 1'b0; ifc.s_valid = 1'b0;
    chk("s_ready_after_last_beat", 32'(ifc.s_ready), 32'd0);
    chk("final_we", 32'(ifc.we), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd1);
    @(negedge clk);
    exp_rdy = 1'b1;
    chk("done_pulse", 32'(done), 32'd1);
    chk("src_rdy_set", 32'(src_rdy), 32'd1);
    chk("busy_cleared", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_single_cycle", 32'(done), 32'd0);
    chk("src_rdy_held", 32'(src_rdy), 32'd1);
    chk("we_count", 32'(we_cnt - base), 32'(total));
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifc.s_valid = 1'b0;
    ifc.s_data  = 16'd0;

    tv[0] = '{nbuf: 8'd0,   len: 8'd4, legal: 1'b0, gap: 0};
    tv[1] = '{nbuf: 8'd1,   len: 8'd1, legal: 1'b1, gap: 0};
    tv[2] = '{nbuf: 8'd7,   len: 8'd4, legal: 1'b0, gap: 0};
    tv[3] = '{nbuf: 8'd2,   len: 8'd3, legal: 1'b1, gap: 40};
    tv[4] = '{nbuf: 8'd255, len: 8'd1, legal: 1'b0, gap: 0};
    tv[5] = '{nbuf: 8'd3,   len: 8'd0, legal: 1'b1, gap: 25};
    tv[6] = '{nbuf: 8'd6,   len: 8'd2, legal: 1'b1, gap: 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_we", 32'(ifc.we), 32'd0);
    chk("rst_wr_addr", ifc.wr_addr, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_src_rdy", 32'(src_rdy), 32'd0);
    chk("rst_s_ready", 32'(ifc.s_ready), 32'd0);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a load
    do_start(8'd4, 8'd10, 1'b1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      ifc.s_valid = 1'b1;
      ifc.s_data  = 16'(16'h100 + i);
      #1;
      if (ifc.s_valid && ifc.s_ready) q.push_back('{addr: 32'(i), data: ifc.s_data});
    end
    @(negedge clk);
    ifc.s_valid = 1'b0;
    chk("mid_load_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_we", 32'(ifc.we), 32'd0);
    chk("async_rst_wr_addr", ifc.wr_addr, 32'd0);
    chk("async_rst_wr_data", 32'(ifc.wr_data), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_s_ready", 32'(ifc.s_ready), 32'd0);
    chk("async_rst_src_rdy", 32'(src_rdy), 32'd0);
    chk("async_rst_done", 32'(done | cfg_err), 32'd0);
    q.delete();
    exp_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full load of every buffer, 256 words each, no gaps
    do_start(8'd6, 8'd0, 1'b1);
    run_load(8'd6, 8'd0, 0, 1'b0);

    // Config vectors: illegal counts, partial loads with gaps, reloads
    for (int i = 0; i < 7; i++) begin
      do_start(tv[i].nbuf, tv[i].len, tv[i].legal);
      if (tv[i].legal) run_load(tv[i].nbuf, tv[i].len, tv[i].gap, 1'b0);
    end

    // A start arriving mid-load must not disturb the running load
    do_start(8'd1, 8'd4, 1'b1);
    run_load(8'd1, 8'd4, 0, 1'b1);
    @(negedge clk);
    chk("no_restart_after_ignored_start", 32'(busy), 32'd0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
